// File: rtl/chi5_shared_det_stage.sv
// Registered output stage behind the duplicated two-share Chi5 S-box pair.
// It re-masks the good beats, forces faulty beats to zero and counts detected faults.
// Once the threshold is reached it locks until reset.
module chi5_shared_det_stage #(
    parameter int unsigned FAULT_THRESHOLD = 1,
    parameter int unsigned CNT_WIDTH       = 4,
    parameter bit          REFRESH_EN      = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 port_in_valid,
    output logic                 port_in_ready,
    input  logic [1:0]           port_a_in,
    input  logic [1:0]           port_b_in,
    input  logic [1:0]           port_c_in,
    input  logic [1:0]           port_d_in,
    input  logic [1:0]           port_e_in,
    input  logic [1:0]           port_det_in,
    input  logic [4:0]           port_rand,
    output logic                 port_out_valid,
    input  logic                 port_out_ready,
    output logic [1:0]           port_a_out,
    output logic [1:0]           port_b_out,
    output logic [1:0]           port_c_out,
    output logic [1:0]           port_d_out,
    output logic [1:0]           port_e_out,
    output logic                 port_fault_out,
    output logic                 port_alarm,
    output logic [CNT_WIDTH-1:0] port_fault_cnt
);

    typedef enum logic [0:0] {StRun, StLocked} state_t;

    state_t               state_q, state_d;
    logic                 out_valid_q;
    logic                 fault_q;
    logic [4:0][1:0]      shares_q, shares_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [4:0][1:0]      in_shares;
    logic [4:0]           mask;
    logic                 accept;
    logic                 in_fault;

    assign in_shares = {port_e_in, port_d_in, port_c_in, port_b_in, port_a_in};
    assign mask      = REFRESH_EN ? port_rand : 5'b0;
    assign in_fault  = (port_det_in != 2'b11);
    assign accept    = port_in_valid && port_in_ready;

    // Same mask bit goes into both shares so the unshared value is preserved.
    always_comb begin
        shares_d = '0;
        for (int k = 0; k < 5; k++) begin
            if (!in_fault) begin
                shares_d[k] = in_shares[k] ^ {mask[k], mask[k]};
            end
        end
    end

    // Saturating fault counter; only advances on an accepted faulty beat.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && in_fault && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Lock in the same edge that captures the threshold-reaching beat.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (accept && in_fault && (32'(cnt_d) >= FAULT_THRESHOLD)) begin
                    state_d = StLocked;
                end
            end
            StLocked: state_d = StLocked;
            default:  state_d = StRun;
        endcase
    end

    // FSM outputs: handshake gating and sticky alarm.
    always_comb begin
        port_in_ready = (state_q == StRun) && (!out_valid_q || port_out_ready);
        port_alarm    = (state_q == StLocked);
    end

    // Pipeline register: capture on accept, drop valid on drain without refill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            fault_q     <= 1'b0;
            shares_q    <= '0;
            cnt_q       <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                fault_q     <= in_fault;
                shares_q    <= shares_d;
            end else if (port_out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign port_out_valid = out_valid_q;
    assign port_fault_out = fault_q;
    assign port_fault_cnt = cnt_q;
    assign port_a_out     = shares_q[0];
    assign port_b_out     = shares_q[1];
    assign port_c_out     = shares_q[2];
    assign port_d_out     = shares_q[3];
    assign port_e_out     = shares_q[4];

endmodule

// File: tb/tb_chi5_shared_det_stage.sv
// Scoreboard bench for chi5_shared_det_stage: a main DUT (threshold 2, 4-bit counter)
// plus a second instance (threshold 3, 2-bit counter) for counter saturation and lock.
module tb_chi5_shared_det_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       in_valid, in_valid2, out_ready;
    logic [1:0] a_in, b_in, c_in, d_in, e_in, det;
    logic [4:0] rnd;

    logic       in_ready, out_valid, fault_out, alarm;
    logic [1:0] a_out, b_out, c_out, d_out, e_out;
    logic [3:0] cnt;

    logic       in_ready2, out_valid2, fault2, alarm2;
    logic [1:0] a2, b2, c2, d2, e2;
    logic [1:0] cnt2;

    chi5_shared_det_stage #(
        .FAULT_THRESHOLD(2),
        .CNT_WIDTH      (4),
        .REFRESH_EN     (1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .port_in_valid(in_valid), .port_in_ready(in_ready),
        .port_a_in(a_in), .port_b_in(b_in), .port_c_in(c_in), .port_d_in(d_in),
        .port_e_in(e_in), .port_det_in(det), .port_rand(rnd),
        .port_out_valid(out_valid), .port_out_ready(out_ready),
        .port_a_out(a_out), .port_b_out(b_out), .port_c_out(c_out), .port_d_out(d_out),
        .port_e_out(e_out), .port_fault_out(fault_out), .port_alarm(alarm),
        .port_fault_cnt(cnt)
    );

    chi5_shared_det_stage #(
        .FAULT_THRESHOLD(3),
        .CNT_WIDTH      (2),
        .REFRESH_EN     (1'b1)
    ) dut2 (
        .clk(clk), .reset(reset),
        .port_in_valid(in_valid2), .port_in_ready(in_ready2),
        .port_a_in(a_in), .port_b_in(b_in), .port_c_in(c_in), .port_d_in(d_in),
        .port_e_in(e_in), .port_det_in(det), .port_rand(rnd),
        .port_out_valid(out_valid2), .port_out_ready(out_ready),
        .port_a_out(a2), .port_b_out(b2), .port_c_out(c2), .port_d_out(d2),
        .port_e_out(e2), .port_fault_out(fault2), .port_alarm(alarm2),
        .port_fault_cnt(cnt2)
    );

    wire [9:0] out_sh = {e_out, d_out, c_out, b_out, a_out};

    typedef struct packed {
        logic [9:0] sh;
        logic       fault;
        logic [3:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [9:0] model(input logic [9:0] sh, input logic [4:0] r);
        logic [9:0] res;
        for (int k = 0; k < 5; k++) begin
            res[2*k]   = sh[2*k]   ^ r[k];
            res[2*k+1] = sh[2*k+1] ^ r[k];
        end
        return res;
    endfunction

    // Monitor: pop one expectation per transferred output beat.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", 32'(out_sh), 32'h0);
            end else begin
                mon_e = q.pop_front();
                chk("beat_data", {21'b0, fault_out, out_sh}, {21'b0, mon_e.fault, mon_e.sh});
                chk("beat_cnt", 32'(cnt), 32'(mon_e.cnt));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [9:0] sh, input logic [1:0] dt, input logic [4:0] r,
                        input logic [9:0] esh, input logic ef, output int waits);
        int w;
        {e_in, d_in, c_in, b_in, a_in} = sh;
        det = dt;
        rnd = r;
        in_valid = 1'b1;
        for (w = 0; w < 20; w++) begin
            @(negedge clk);
            if (in_ready) break;
            @(posedge clk);
            #1;
        end
        waits = w;
        if (w == 20) begin
            chk("accept_timeout", 32'h0, 32'h1);
        end else begin
            if (ef && exp_cnt < 15) exp_cnt++;
            q.push_back('{sh: esh, fault: ef, cnt: 4'(exp_cnt)});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [9:0] rsh;
    logic [4:0] rr;
    int         w;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1;
        {e_in, d_in, c_in, b_in, a_in} = '0; det = 2'b11; rnd = '0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_shares", 32'(out_sh), 32'h0);
        chk("rst_fault", 32'(fault_out), 32'h0);
        chk("rst_alarm", 32'(alarm), 32'h0);
        chk("rst_cnt", 32'(cnt), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_cnt2", 32'(cnt2), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic refresh: a=10 with mask a=1 becomes 01.
        send(10'b00_00_00_00_10, 2'b11, 5'b00001, 10'b00_00_00_00_01, 1'b0, w);
        chk("t1_latency_valid", 32'(out_valid), 32'h1);
        idle(2);

        // Stall for 3 cycles, then back-to-back accepts.
        out_ready = 1'b0;
        send(10'b01_10_00_11_01, 2'b11, 5'b10110, 10'b10_10_11_00_01, 1'b0, w);
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t2_stall_in_ready", 32'(in_ready), 32'h0);
            chk("t2_stall_valid", 32'(out_valid), 32'h1);
            chk("t2_stall_data", 32'(out_sh), 32'(10'b10_10_11_00_01));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(10'h3FF, 2'b11, 5'b11111, 10'h000, 1'b0, w);
        chk("t2_no_bubble_a", 32'(w), 32'h0);
        send(10'h000, 2'b11, 5'b00101, 10'b00_00_11_00_11, 1'b0, w);
        chk("t2_no_bubble_b", 32'(w), 32'h0);
        idle(2);

        // Fault counting and lock at threshold 2.
        send(10'h2AB, 2'b10, 5'b10101, 10'h000, 1'b1, w);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_alarm_after_1", 32'(alarm), 32'h0);
        chk("t3_in_ready_after_1", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(10'h155, 2'b01, 5'b00000, 10'h000, 1'b1, w);
        in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("t3_alarm", 32'(alarm), 32'h1);
            chk("t3_in_ready_locked", 32'(in_ready), 32'h0);
            chk("t3_pending_valid", 32'(out_valid), 32'h1);
            chk("t3_pending_fault", 32'(fault_out), 32'h1);
            chk("t3_cnt", 32'(cnt), 32'h2);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(2);
        {e_in, d_in, c_in, b_in, a_in} = 10'h0F0; det = 2'b00; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t3_locked_refuse", 32'(in_ready), 32'h0);
            chk("t3_locked_no_valid", 32'(out_valid), 32'h0);
            chk("t3_locked_cnt_hold", 32'(cnt), 32'h2);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("t3_rst_alarm", 32'(alarm), 32'h0);
        chk("t3_rst_cnt", 32'(cnt), 32'h0);
        chk("t3_rst_in_ready", 32'(in_ready), 32'h1);
        q.delete();
        exp_cnt = 0;
        #3 reset = 1'b0;

        // Reset while a beat is held: discarded immediately.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(10'h3C3, 2'b11, 5'b01010, model(10'h3C3, 5'b01010), 1'b0, w);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_held_valid", 32'(out_valid), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(out_valid), 32'h0);
        chk("t5_rst_shares", 32'(out_sh), 32'h0);
        chk("t5_rst_fault", 32'(fault_out), 32'h0);
        q.delete();
        exp_cnt = 0;
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("t5_discarded", 32'(out_valid), 32'h0);
        out_ready = 1'b1;

        // Streaming good beats with random data and masks.
        for (int i = 0; i < 20; i++) begin
            rsh = 10'($urandom);
            rr  = 5'($urandom);
            send(rsh, 2'b11, rr, model(rsh, rr), 1'b0, w);
        end
        idle(3);
        chk("t4_cnt_zero", 32'(cnt), 32'h0);

        // Second instance: 2-bit counter, threshold 3.
        det = 2'b00;
        in_valid2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_in_ready", 32'(in_ready2), 32'h1);
            @(posedge clk); #1;
            chk("t6_cnt", 32'(cnt2), 32'(i + 1));
            chk("t6_alarm", 32'(alarm2), 32'(i == 2));
        end
        repeat (3) begin
            @(negedge clk);
            chk("t6_refuse", 32'(in_ready2), 32'h0);
            chk("t6_cnt_hold", 32'(cnt2), 32'h3);
        end
        chk("t6_drained", 32'(out_valid2), 32'h0);
        in_valid2 = 1'b0;

        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
